// File: rtl/seg7_rx.sv
// Seven-segment pattern receiver: synchronizes, debounces and decodes a hex digit.
// Optional sequence checker compiled in with `define SEG7_RX_SEQ_CHECK_EN.
module seg7_rx #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       new_pulse,
  output logic       err_pulse,
  output logic [7:0] err_count,
  output logic       seq_err
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_ARM = 8'(STABLE_CYCLES - 1);

  // Returns {legal, digit}; anything outside the hex table is illegal.
  function automatic logic [4:0] seg_decode(input logic [6:0] pat);
    logic [4:0] r;
    r = 5'b0_0000;
    case (pat)
      7'h3F: r = 5'b1_0000;
      7'h06: r = 5'b1_0001;
      7'h5B: r = 5'b1_0010;
      7'h4F: r = 5'b1_0011;
      7'h66: r = 5'b1_0100;
      7'h6D: r = 5'b1_0101;
      7'h7D: r = 5'b1_0110;
      7'h07: r = 5'b1_0111;
      7'h7F: r = 5'b1_1000;
      7'h6F: r = 5'b1_1001;
      7'h77: r = 5'b1_1010;
      7'h7C: r = 5'b1_1011;
      7'h39: r = 5'b1_1100;
      7'h5E: r = 5'b1_1101;
      7'h79: r = 5'b1_1110;
      7'h71: r = 5'b1_1111;
      default: r = 5'b0_0000;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [6:0] seg_p0, seg_p1, seg_p2;
  logic [7:0] stab_cnt_p2;
  logic [6:0] last_pat;
  logic       same_p1;
  logic       accept_p2;
  logic [4:0] dec_p2;
  logic       legal_p2;
  logic [3:0] dec_digit_p2;

  always_comb begin
    same_p1      = (seg_p1 == seg_p2);
    accept_p2    = same_p1 && (stab_cnt_p2 >= CNT_ARM) && (seg_p2 != last_pat);
    dec_p2       = seg_decode(seg_p2);
    legal_p2     = dec_p2[4];
    dec_digit_p2 = dec_p2[3:0];
  end

  // Stage p0/p1: two-flop synchronizer; stage p2: previous sample and stability count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_p0      <= 7'h00;
      seg_p1      <= 7'h00;
      seg_p2      <= 7'h00;
      stab_cnt_p2 <= 8'd0;
    end else begin
      seg_p0 <= seg_in;
      seg_p1 <= seg_p0;
      seg_p2 <= seg_p1;
      if (!same_p1)
        stab_cnt_p2 <= 8'd1;
      else if (stab_cnt_p2 < CNT_MAX)
        stab_cnt_p2 <= stab_cnt_p2 + 8'd1;
    end
  end

  // Output stage: acceptance updates digit/status and fires exactly one strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_pat    <= 7'h00;
      digit       <= 4'd0;
      digit_valid <= 1'b0;
      new_pulse   <= 1'b0;
      err_pulse   <= 1'b0;
      err_count   <= 8'd0;
    end else begin
      new_pulse <= accept_p2 && legal_p2;
      err_pulse <= accept_p2 && !legal_p2;
      if (accept_p2) begin
        last_pat <= seg_p2;
        if (legal_p2) begin
          digit       <= dec_digit_p2;
          digit_valid <= 1'b1;
        end else begin
          digit_valid <= 1'b0;
          err_count   <= sat_inc8(err_count);
        end
      end
    end
  end

`ifdef SEG7_RX_SEQ_CHECK_EN
  // The first legal digit after reset or after an illegal pattern only arms the check.
  logic seq_armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_armed <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      seq_err <= accept_p2 && legal_p2 && seq_armed && (dec_digit_p2 != (digit + 4'd1));
      if (accept_p2)
        seq_armed <= legal_p2;
    end
  end
`else
  assign seq_err = 1'b0;
`endif

endmodule
